traffic_gen: RTL and testbench
==============================

Name: traffic_gen

Overview:
- Synthesizable LFSR-based packet source. Sits directly upstream of the packetizer on a module node and drives its i_data_in/i_valid_in/i_dest_in/i_ready_out interface.
- Emits a deterministic, seed-reproducible sequence of N_PACKETS data words to a programmable destination, with a programmable inter-packet gap.
- Reports completion, packets sent and elapsed cycles, so on-chip latency/throughput runs need no bench-side producer.

Parameters:
- WIDTH_DATA, 400: payload width per packet, in bits.
- ADDRESS_WIDTH, 4: destination node address width.
- N_PACKETS, 100: packets per run; must be at least 1.
- SEED, 32'hBAADF00D: LFSR load value at run start; a zero value is replaced by 32'h1.
- GAP_WIDTH, 8: width of the gap-cycle input.

Ports:
- clk  in  1  module (rtl) clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start a run; sampled only in IDLE or DONE
- i_dest  in  ADDRESS_WIDTH  destination, latched at start
- i_gap  in  GAP_WIDTH  idle cycles after each transfer, latched at start
- o_data_out  out  WIDTH_DATA  payload to packetizer
- o_valid_out  out  1  payload valid
- o_dest_out  out  ADDRESS_WIDTH  destination to packetizer
- o_ready_in  in  1  packetizer ready
- o_done  out  1  run complete (level)
- o_sent_count  out  32  transfers completed this run
- o_cycles  out  32  cycles spent in SEND+GAP this run, saturating at 32'hFFFFFFFF

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; LFSR is loaded with SEED.
  - Reset asserted mid-run aborts the run at the next edge. No partial state survives.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE & i_start -> SEND. Same edge: load LFSR=SEED, sent=0, cycles=0, latch i_dest and i_gap.
  - SEND: o_valid_out=1. A transfer occurs when o_valid_out & o_ready_in.
    - On transfer: LFSR advances and sent increments.
    - If sent+1==N_PACKETS -> DONE.
    - Else if gap!=0 -> GAP, with the gap counter loaded to gap.
    - Else stay in SEND (back-to-back).
  - GAP: o_valid_out=0. Counter decrements each cycle; on the cycle it reaches 1 -> SEND. Exactly gap idle cycles.
  - DONE: o_done=1, o_valid_out=0; counters hold. i_start restarts the run exactly as from IDLE, and o_done drops on that edge.
  - i_start in SEND/GAP is ignored.
- Handshake:
  - While o_valid_out & !o_ready_in: o_data_out and o_dest_out are held stable and the LFSR does not advance.
  - Valid is never withdrawn without a transfer.
- Latency: first o_valid_out occurs the cycle after the edge that samples i_start.
- o_cycles increments on every cycle the FSM is in SEND or GAP. It counts the final transfer cycle but not the DONE cycles.
- LFSR:
  - 32-bit Galois, right-shift: next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - Never zero.
- Payload:
  - o_data_out word k (bits 32k+31:32k) = s ^ (k*32'h9E3779B9), mod 2^32.
  - Top partial word is truncated to WIDTH_DATA.
  - Computed combinationally from the registered LFSR state; no extra latency.
- o_dest_out is the latched destination; it is 0 whenever not in SEND.

Decomposition:
- Package noc_traffic_pkg:
  - LFSR_POLY = 32'h80200003 and GOLDEN = 32'h9E3779B9.
  - Function lfsr_next(s).
  - Function expand_payload(s, width) returning the payload vector.
  - The traffic_state_t enum {IDLE, SEND, GAP, DONE}.
  - The matching checker on the depacketizer side reuses this package.
- One sub-module, lfsr32: inputs load, load_val, advance; output state. traffic_gen instantiates it once.

Test Plan:
- Basic run: reset 2 cycles; N_PACKETS=4, i_dest=1, i_gap=0, o_ready_in=1; pulse i_start.
  - Valid is high for 4 consecutive cycles starting the cycle after start.
  - Packet 0: word0=32'hBAADF00D, word1=32'h249A89B4. Packet 1: word0=32'hDD76F805.
  - o_dest_out=1. Then o_done=1, o_sent_count=4, o_cycles=4.
- Backpressure: hold o_ready_in=0 for 3 cycles during packet 1.
  - o_data_out word0 stays 32'hDD76F805 and o_dest_out stays 1 throughout.
  - o_sent_count stays 1 during the stall. Final o_cycles=7.
- Gap: i_gap=2, N_PACKETS=4, ready=1.
  - Valid pattern 1,0,0,1,0,0,1,0,0,1.
  - o_cycles=10, o_sent_count=4.
- Start handling:
  - i_start pulsed during SEND is ignored; the packet sequence and counts are unchanged.
  - i_start in DONE restarts: o_done falls, packet 0 word0=32'hBAADF00D again, counts restart from 0.
- Reset mid-run: assert rst after 2 transfers.
  - Next cycle: valid=0, done=0, sent=0, cycles=0.
  - A new start reproduces the sequence from 32'hBAADF00D.
- Stalled at entry: o_ready_in=0 from start for 5 cycles, then 1.
  - First transfer carries 32'hBAADF00D.
  - o_cycles includes the 5 stall cycles.

Source files
------------

// File: rtl/noc_traffic_pkg.sv
// Shared definitions for the LFSR traffic source and its depacketizer-side checker:
// state encoding, LFSR step and payload expansion.
package noc_traffic_pkg;

   localparam logic [31:0] LFSR_POLY        = 32'h80200003;
   localparam logic [31:0] GOLDEN           = 32'h9E3779B9;
   localparam int unsigned MAX_PAYLOAD_BITS = 1024;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } traffic_state_t;

   // Galois right-shift step; a non-zero state never maps to zero.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [31:0] payload_word(input logic [31:0] s, input int unsigned k);
      logic [31:0] kk;
      kk = k[31:0];
      return s ^ (kk * GOLDEN);
   endfunction

   // Full payload for a given LFSR state; bits at or above width are cleared.
   function automatic logic [MAX_PAYLOAD_BITS-1:0] expand_payload(input logic [31:0] s,
                                                                   input int unsigned width);
      logic [MAX_PAYLOAD_BITS-1:0] v;
      v = '0;
      for (int unsigned k = 0; k < MAX_PAYLOAD_BITS / 32; k++) begin
         v[32*k +: 32] = payload_word(s, k);
      end
      for (int unsigned b = 0; b < MAX_PAYLOAD_BITS; b++) begin
         if (b >= width) begin
            v[b] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/traffic_gen_if.sv
// Payload handshake between the traffic source (master) and the packetizer (slave).
interface traffic_gen_if #(
   parameter int WIDTH_DATA    = 400,
   parameter int ADDRESS_WIDTH = 4
);
   logic [WIDTH_DATA-1:0]    o_data_out;
   logic                     o_valid_out;
   logic [ADDRESS_WIDTH-1:0] o_dest_out;
   logic                     o_ready_in;

   modport master (
      output o_data_out,
      output o_valid_out,
      output o_dest_out,
      input  o_ready_in
   );

   modport slave (
      input  o_data_out,
      input  o_valid_out,
      input  o_dest_out,
      output o_ready_in
   );
endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance; a zero load value becomes 1.
module lfsr32
   import noc_traffic_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        advance,
   output logic [31:0] state
);
   localparam logic [31:0] RESET_EFF = (RESET_VAL == 32'h0) ? 32'h1 : RESET_VAL;

   logic [31:0] state_q;
   logic [31:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (load_val == 32'h0) ? 32'h1 : load_val;
      end else if (advance) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_EFF;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;
endmodule

// File: rtl/traffic_gen.sv
// LFSR-driven packet source: emits N_PACKETS seed-reproducible payloads to a latched
// destination with a programmable gap, and reports sent count and elapsed cycles.
module traffic_gen
   import noc_traffic_pkg::*;
#(
   parameter int          WIDTH_DATA    = 400,
   parameter int          ADDRESS_WIDTH = 4,
   parameter int unsigned N_PACKETS     = 100,
   parameter logic [31:0] SEED          = 32'hBAADF00D,
   parameter int          GAP_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [ADDRESS_WIDTH-1:0] i_dest,
   input  logic [GAP_WIDTH-1:0]     i_gap,
   traffic_gen_if.master            bus,
   output logic                     o_done,
   output logic [31:0]              o_sent_count,
   output logic [31:0]              o_cycles
);
   localparam int          N_FULL       = WIDTH_DATA / 32;
   localparam int          REM          = WIDTH_DATA % 32;
   localparam logic [31:0] N_PACKETS_32 = N_PACKETS[31:0];
   localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

   traffic_state_t           state_q,    state_d;
   logic                     valid_q,    valid_d;
   logic                     done_q,     done_d;
   logic [ADDRESS_WIDTH-1:0] dest_out_q, dest_out_d;
   logic [ADDRESS_WIDTH-1:0] dest_q,     dest_d;
   logic [GAP_WIDTH-1:0]     gap_q,      gap_d;
   logic [GAP_WIDTH-1:0]     gap_cnt_q,  gap_cnt_d;
   logic [31:0]              sent_q,     sent_d;
   logic [31:0]              cycles_q,   cycles_d;

   logic        lfsr_load;
   logic        lfsr_advance;
   logic [31:0] lfsr_state;

   lfsr32 #(
      .RESET_VAL (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (SEED),
      .advance  (lfsr_advance),
      .state    (lfsr_state)
   );

   // Payload is a pure function of the registered LFSR state, so it stays stable under stall.
   logic [WIDTH_DATA-1:0] payload;

   for (genvar gi = 0; gi < N_FULL; gi++) begin : g_word
      assign payload[32*gi +: 32] = payload_word(lfsr_state, gi);
   end

   if (REM != 0) begin : g_tail
      assign payload[WIDTH_DATA-1 : 32*N_FULL] = REM'(payload_word(lfsr_state, N_FULL));
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      done_d       = done_q;
      dest_out_d   = dest_out_q;
      dest_d       = dest_q;
      gap_d        = gap_q;
      gap_cnt_d    = gap_cnt_q;
      sent_d       = sent_q;
      cycles_d     = cycles_q;
      lfsr_load    = 1'b0;
      lfsr_advance = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               state_d    = SEND;
               valid_d    = 1'b1;
               done_d     = 1'b0;
               dest_d     = i_dest;
               dest_out_d = i_dest;
               gap_d      = i_gap;
               sent_d     = 32'h0;
               cycles_d   = 32'h0;
               lfsr_load  = 1'b1;
            end
         end
         SEND: begin
            cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
            if (bus.o_ready_in) begin
               lfsr_advance = 1'b1;
               sent_d       = sent_q + 32'd1;
               if (sent_q + 32'd1 == N_PACKETS_32) begin
                  state_d    = DONE;
                  valid_d    = 1'b0;
                  done_d     = 1'b1;
                  dest_out_d = '0;
               end else if (gap_q != '0) begin
                  state_d    = GAP;
                  valid_d    = 1'b0;
                  dest_out_d = '0;
                  gap_cnt_d  = gap_q;
               end
            end
         end
         GAP: begin
            cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
            if (gap_cnt_q == GAP_ONE) begin
               state_d    = SEND;
               valid_d    = 1'b1;
               dest_out_d = dest_q;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         dest_out_q <= '0;
         dest_q     <= '0;
         gap_q      <= '0;
         gap_cnt_q  <= '0;
         sent_q     <= 32'h0;
         cycles_q   <= 32'h0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         dest_out_q <= dest_out_d;
         dest_q     <= dest_d;
         gap_q      <= gap_d;
         gap_cnt_q  <= gap_cnt_d;
         sent_q     <= sent_d;
         cycles_q   <= cycles_d;
      end
   end

   assign bus.o_valid_out = valid_q;
   assign bus.o_dest_out  = dest_out_q;
   assign bus.o_data_out  = valid_q ? payload : '0;
   assign o_done          = done_q;
   assign o_sent_count    = sent_q;
   assign o_cycles        = cycles_q;
endmodule

// File: tb/tb_traffic_gen.sv
// Directed bench for traffic_gen: basic run, backpressure, gap, start handling,
// mid-run reset and stall at entry, with hand-computed LFSR payload words.
module tb_traffic_gen;
   import noc_traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_start = 1'b0;
   logic [3:0] i_dest = 4'd0;
   logic [7:0] i_gap = 8'd0;
   logic       o_done;
   logic [31:0] o_sent_count;
   logic [31:0] o_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   // Word 0 of packets 0..3 starting from seed BAADF00D.
   logic [31:0] pkt_w0 [4] = '{32'hBAADF00D, 32'hDD76F805, 32'hEE9B7C01, 32'hF76DBE03};
   logic [9:0]  gap_pattern = 10'b1001001001;

   traffic_gen_if #(.WIDTH_DATA(400), .ADDRESS_WIDTH(4)) bus ();

   traffic_gen #(
      .WIDTH_DATA    (400),
      .ADDRESS_WIDTH (4),
      .N_PACKETS     (4),
      .SEED          (32'hBAADF00D),
      .GAP_WIDTH     (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_dest       (i_dest),
      .i_gap        (i_gap),
      .bus          (bus),
      .o_done       (o_done),
      .o_sent_count (o_sent_count),
      .o_cycles     (o_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] word(input int k);
      return bus.o_data_out[32*k +: 32];
   endfunction

   initial begin
      bus.o_ready_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_valid", {31'd0, bus.o_valid_out}, 32'd0);
      chk("reset_done", {31'd0, o_done}, 32'd0);
      chk("reset_sent", o_sent_count, 32'd0);
      chk("reset_cycles", o_cycles, 32'd0);
      chk("reset_dest", {28'd0, bus.o_dest_out}, 32'd0);
      chk("reset_data_w0", word(0), 32'd0);

      // Basic run: gap 0, ready always high.
      i_dest = 4'd1; i_gap = 8'd0; bus.o_ready_in = 1'b1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("basic_valid0", {31'd0, bus.o_valid_out}, 32'd1);
      chk("basic_p0_w0", word(0), 32'hBAADF00D);
      chk("basic_p0_w1", word(1), 32'h249A89B4);
      chk("basic_p0_tail", {16'd0, bus.o_data_out[399:384]}, 32'h000044A1);
      chk("basic_dest", {28'd0, bus.o_dest_out}, 32'd1);
      for (int p = 1; p < 4; p++) begin
         tick();
         chk($sformatf("basic_valid%0d", p), {31'd0, bus.o_valid_out}, 32'd1);
         chk($sformatf("basic_p%0d_w0", p), word(0), pkt_w0[p]);
         chk($sformatf("basic_sent%0d", p), o_sent_count, p);
      end
      tick();
      chk("basic_valid_end", {31'd0, bus.o_valid_out}, 32'd0);
      chk("basic_done", {31'd0, o_done}, 32'd1);
      chk("basic_sent", o_sent_count, 32'd4);
      chk("basic_cycles", o_cycles, 32'd4);
      chk("basic_dest_idle", {28'd0, bus.o_dest_out}, 32'd0);

      // Backpressure: restart from DONE, stall 3 cycles on packet 1.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("bp_done_fell", {31'd0, o_done}, 32'd0);
      chk("bp_p0_w0", word(0), 32'hBAADF00D);
      chk("bp_sent_restart", o_sent_count, 32'd0);
      tick();
      chk("bp_p1_w0", word(0), 32'hDD76F805);
      bus.o_ready_in = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk($sformatf("bp_stall%0d_w0", s), word(0), 32'hDD76F805);
         chk($sformatf("bp_stall%0d_dest", s), {28'd0, bus.o_dest_out}, 32'd1);
         chk($sformatf("bp_stall%0d_sent", s), o_sent_count, 32'd1);
         chk($sformatf("bp_stall%0d_valid", s), {31'd0, bus.o_valid_out}, 32'd1);
      end
      bus.o_ready_in = 1'b1;
      tick();
      chk("bp_p2_w0", word(0), 32'hEE9B7C01);
      tick();
      chk("bp_p3_w0", word(0), 32'hF76DBE03);
      tick();
      chk("bp_done", {31'd0, o_done}, 32'd1);
      chk("bp_sent", o_sent_count, 32'd4);
      chk("bp_cycles", o_cycles, 32'd7);

      // Gap of 2 idle cycles after every transfer.
      i_gap = 8'd2; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("gap_valid_c%0d", c), {31'd0, bus.o_valid_out}, {31'd0, gap_pattern[9-c]});
         if (c == 6) chk("gap_p2_w0", word(0), 32'hEE9B7C01);
         if (c == 1) chk("gap_dest_idle", {28'd0, bus.o_dest_out}, 32'd0);
         tick();
      end
      chk("gap_done", {31'd0, o_done}, 32'd1);
      chk("gap_sent", o_sent_count, 32'd4);
      chk("gap_cycles", o_cycles, 32'd10);

      // i_start held during SEND must be ignored.
      i_gap = 8'd0; i_start = 1'b1;
      tick();
      chk("ign_p0_w0", word(0), 32'hBAADF00D);
      tick();
      chk("ign_p1_w0", word(0), 32'hDD76F805);
      chk("ign_sent1", o_sent_count, 32'd1);
      tick();
      i_start = 1'b0;
      chk("ign_p2_w0", word(0), 32'hEE9B7C01);
      chk("ign_sent2", o_sent_count, 32'd2);
      tick();
      chk("ign_p3_w0", word(0), 32'hF76DBE03);
      tick();
      chk("ign_done", {31'd0, o_done}, 32'd1);
      chk("ign_sent", o_sent_count, 32'd4);
      chk("ign_cycles", o_cycles, 32'd4);

      // Reset after two transfers aborts the run.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      tick();
      chk("rst_pre_sent", o_sent_count, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, bus.o_valid_out}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_sent", o_sent_count, 32'd0);
      chk("rst_cycles", o_cycles, 32'd0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("rst_restart_w0", word(0), 32'hBAADF00D);
      tick();
      chk("rst_restart_p1", word(0), 32'hDD76F805);
      tick();
      tick();
      tick();
      chk("rst_restart_done", {31'd0, o_done}, 32'd1);

      // Stalled at entry for 5 cycles.
      bus.o_ready_in = 1'b0; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk($sformatf("entry_stall%0d_w0", s), word(0), 32'hBAADF00D);
         chk($sformatf("entry_stall%0d_sent", s), o_sent_count, 32'd0);
      end
      bus.o_ready_in = 1'b1;
      tick();
      chk("entry_p1_w0", word(0), 32'hDD76F805);
      chk("entry_sent1", o_sent_count, 32'd1);
      tick();
      tick();
      tick();
      chk("entry_done", {31'd0, o_done}, 32'd1);
      chk("entry_sent", o_sent_count, 32'd4);
      chk("entry_cycles", o_cycles, 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
